coin_scheduler: RTL

COIN_SCHEDULER -- requirements
Module: coin_scheduler

---
 rtl/vend_pkg.sv | 29 ++
 rtl/coin_pend_ctr.sv | 35 +++
 rtl/coin_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the coin scheduler: slot indices, FSM states,
// widths, and the fixed 5 > 2 > 1 issue-priority helper.
package vend_pkg;

  localparam int unsigned NSLOT   = 3;
  localparam int unsigned SLOT1   = 0;
  localparam int unsigned SLOT2   = 1;
  localparam int unsigned SLOT5   = 2;
  localparam int unsigned STOCK_W = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned GAP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // One-hot pick of the highest-value slot that has a coin available.
  function automatic logic [NSLOT-1:0] pick_slot(input logic [NSLOT-1:0] avail);
    logic [NSLOT-1:0] sel;
    sel = '0;
    if (avail[SLOT5])      sel[SLOT5] = 1'b1;
    else if (avail[SLOT2]) sel[SLOT2] = 1'b1;
    else if (avail[SLOT1]) sel[SLOT1] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/coin_pend_ctr.sv
// Per-slot saturating pending-coin counter. A coin that cannot be accepted
// raises a one-cycle registered reject on the following cycle.
module coin_pend_ctr
  import vend_pkg::*;
#(
  parameter int unsigned PEND_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin,
  input  logic             dec,
  input  logic             blocked,
  output logic [CNT_W-1:0] count,
  output logic             reject
);

  logic accept;

  assign accept = coin && !blocked && (count != CNT_W'(PEND_MAX));

  // Increment and decrement in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      reject <= 1'b0;
    end else begin
      reject <= coin && !accept;
      if (accept && !dec)
        count <= count + CNT_W'(1);
      else if (dec && !accept)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/coin_scheduler.sv
// Coin scheduler: buffers coin-sensor pulses per slot and re-issues them one at
// a time with an enforced idle gap, and tracks soda stock and dispense requests.
module coin_scheduler
  import vend_pkg::*;
#(
  parameter int unsigned GAP        = 2,
  parameter int unsigned SODA_STOCK = 15,
  parameter int unsigned PEND_MAX   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coin1_i,
  input  logic               coin2_i,
  input  logic               coin5_i,
  input  logic               soda_i,
  input  logic               disp_ack_i,
  input  logic               refill_i,
  output logic               in1_o,
  output logic               in2_o,
  output logic               in5_o,
  output logic               disp_req_o,
  output logic [NSLOT-1:0]   reject_o,
  output logic [STOCK_W-1:0] stock_o,
  output logic               empty_o
);

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NSLOT-1:0]   in_q, in_d;
  logic [NSLOT-1:0]   avail;
  logic               start;
  logic [CNT_W-1:0]   cnt [NSLOT];
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               empty_q, disp_req_q, ack_q;

  coin_pend_ctr #(.PEND_MAX(PEND_MAX)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .coin(coin1_i), .dec(in_q[SLOT1]),
    .blocked(empty_q), .count(cnt[SLOT1]), .reject(reject_o[SLOT1])
  );
  coin_pend_ctr #(.PEND_MAX(PEND_MAX)) u_slot2 (
    .clk(clk), .rst_n(rst_n), .coin(coin2_i), .dec(in_q[SLOT2]),
    .blocked(empty_q), .count(cnt[SLOT2]), .reject(reject_o[SLOT2])
  );
  coin_pend_ctr #(.PEND_MAX(PEND_MAX)) u_slot5 (
    .clk(clk), .rst_n(rst_n), .coin(coin5_i), .dec(in_q[SLOT5]),
    .blocked(empty_q), .count(cnt[SLOT5]), .reject(reject_o[SLOT5])
  );

  // A coin being issued this cycle no longer counts as available.
  always_comb begin
    for (int k = 0; k < int'(NSLOT); k++)
      avail[k] = (cnt[k] != '0) && !(in_q[k] && (cnt[k] == CNT_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      in_q    <= in_d;
    end
  end

  // Once the gap is served, go straight back to ISSUE if work is waiting.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    in_d    = '0;
    start   = (|avail) && !disp_req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          in_d    = pick_slot(avail);
        end
      end
      ST_ISSUE: begin
        if (GAP != 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP - 1);
        end else if (start) begin
          state_d = ST_ISSUE;
          in_d    = pick_slot(avail);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (start) begin
          state_d = ST_ISSUE;
          in_d    = pick_slot(avail);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stock_d = stock_q;
    if (refill_i)
      stock_d = STOCK_W'(SODA_STOCK);
    else if (soda_i && (stock_q != '0))
      stock_d = stock_q - STOCK_W'(1);
  end

  // Acknowledge takes effect one edge after it is sampled; a new vend wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stock_q    <= STOCK_W'(SODA_STOCK);
      empty_q    <= 1'b0;
      disp_req_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      stock_q <= stock_d;
      empty_q <= (stock_d == '0);
      ack_q   <= disp_ack_i;
      if (soda_i)
        disp_req_q <= 1'b1;
      else if (ack_q)
        disp_req_q <= 1'b0;
    end
  end

  assign in1_o      = in_q[SLOT1];
  assign in2_o      = in_q[SLOT2];
  assign in5_o      = in_q[SLOT5];
  assign disp_req_o = disp_req_q;
  assign stock_o    = stock_q;
  assign empty_o    = empty_q;

endmodule
